intc_arbiter: RTL and testbench

- Interrupt controller and arbiter in front of the multicycle CPU controller.
- Synchronises external interrupt lines and latches them as pending bits.
- Applies the software mask (loaded from the accumulator) and picks one request by fixed priority.
- Presents intPending, intId and intVector to the controller and consumes its clrPend, intDisable and intEnable handshakes.

---
 rtl/intc_pkg.sv | 33 +++
 rtl/irq_sync_edge.sv | 53 +++++
 rtl/intc_arbiter.sv | 155 +++++++++++++++
 tb/tb_intc_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intc_pkg
// Description : Shared types, default sizes and the priority encoder used by
//               the interrupt controller / arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package intc_pkg;

  localparam int         NUM_IRQ_DEF  = 4;
  localparam int         IDW_DEF      = 2;
  localparam int         VEC_W_DEF    = 8;
  localparam logic [7:0] VEC_BASE_DEF = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Index of the lowest set bit (lowest index has highest priority).
  // Sized for the largest supported line count; callers zero-extend.
  function automatic logic [2:0] prio_enc(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Two-flop synchroniser for one asynchronous interrupt line,
//               followed by an edge register producing a one-cycle rise pulse.
// Build macro : INTC_LEVEL_EN - level-sensitive build; the edge register is
//               not built and the synchronised level is exported instead.
// Ports       : clk     - system clock, rising edge
//               rst_n   - asynchronous active-low reset
//               i_irq   - raw interrupt line (asynchronous)
//               o_level - synchronised level   (INTC_LEVEL_EN builds)
//               o_rise  - synchronised rise    (edge-latched builds)
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_irq,
`ifdef INTC_LEVEL_EN
  output logic o_level
`else
  output logic o_rise
`endif
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_irq;
      r_s2 <= r_s1;
    end
  end

`ifdef INTC_LEVEL_EN
  assign o_level = r_s2;
`else
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s3 <= 1'b0;
    else        r_s3 <= r_s2;
  end

  assign o_rise = r_s2 & ~r_s3;
`endif

endmodule
`default_nettype wire

// File: rtl/intc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : intc_arbiter
// Description : Interrupt controller / fixed-priority arbiter in front of the
//               CPU controller. Synchronises and latches interrupt lines,
//               applies the software mask and global enable, and runs the
//               IDLE -> REQ -> SERVICE handshake with the controller.
// Build macro : INTC_LEVEL_EN - pending follows the synchronised line level
//               and is not cleared by clrPend (default: edge-latched).
// Ports       : clk, rst_n   - clock / asynchronous active-low reset
//               irq          - raw interrupt lines
//               maskIn/MASKld- mask load value / strobe (1 = masked)
//               intEnable    - set global enable, return-from-interrupt
//               intDisable   - clear global enable (wins over intEnable)
//               clrPend      - controller accepts the presented interrupt
//               intPending   - request to controller
//               intId        - presented / serviced line index
//               intVector    - handler address (VEC_BASE + intId)
//               inService    - handler running
//               maskOut      - mask readback
// Revision    : 1.0 - initial release
// ============================================================================
module intc_arbiter
  import intc_pkg::*;
#(
  parameter int               NUM_IRQ  = NUM_IRQ_DEF,
  parameter int               IDW      = IDW_DEF,
  parameter int               VEC_W    = VEC_W_DEF,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] maskIn,
  input  logic               MASKld,
  input  logic               intEnable,
  input  logic               intDisable,
  input  logic               clrPend,
  output logic               intPending,
  output logic [IDW-1:0]     intId,
  output logic [VEC_W-1:0]   intVector,
  output logic               inService,
  output logic [NUM_IRQ-1:0] maskOut
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_id;
  logic               w_id_load;
  logic [NUM_IRQ-1:0] r_mask;
  logic               r_gen;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_id_oh;
  logic               w_id_elig;
  logic [IDW-1:0]     w_winner;
  logic               w_accept;

`ifdef INTC_LEVEL_EN
  logic [NUM_IRQ-1:0] w_level;
`else
  logic [NUM_IRQ-1:0] w_rise;
`endif

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_irq   (irq[i]),
`ifdef INTC_LEVEL_EN
      .o_level (w_level[i])
`else
      .o_rise  (w_rise[i])
`endif
    );
  end

  assign w_accept = (r_state == REQ) && clrPend;
  assign w_id_oh  = NUM_IRQ'(1) << r_id;

`ifdef INTC_LEVEL_EN
  assign w_pending = w_level;
`else
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_clr;

  assign w_clr = w_accept ? w_id_oh : '0;

  // A rise arriving in the same cycle as the clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_rise | (r_pending & ~w_clr);
  end

  assign w_pending = r_pending;
`endif

  assign w_eligible = w_pending & ~r_mask;
  assign w_id_elig  = |(w_eligible & w_id_oh);
  assign w_winner   = IDW'(prio_enc(8'(w_eligible)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_mask <= '0;
    else if (MASKld) r_mask <= maskIn;
  end

  // Disable dominates; accepting an interrupt also drops the global enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_gen <= 1'b0;
    else if (intDisable) r_gen <= 1'b0;
    else if (w_accept)   r_gen <= 1'b0;
    else if (intEnable)  r_gen <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_gen && (|w_eligible)) begin
          w_state_nxt = REQ;
          w_id_load   = 1'b1;
        end
      end
      REQ: begin
        if (clrPend)                      w_state_nxt = SERVICE;
        else if (intDisable || !w_id_elig) w_state_nxt = IDLE;
      end
      SERVICE: begin
        if (intEnable) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // intId only changes on the IDLE -> REQ transition, so it is frozen in
  // REQ and held through SERVICE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_id <= '0;
    else if (w_id_load) r_id <= w_winner;
  end

  assign intPending = (r_state == REQ);
  assign inService  = (r_state == SERVICE);
  assign intId      = r_id;
  assign intVector  = VEC_BASE + VEC_W'(r_id);
  assign maskOut    = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_intc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_intc_arbiter
// Description : Directed self-checking bench for intc_arbiter (default
//               parameters, NUM_IRQ=4, VEC_BASE=8'hF0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intc_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq;
  logic [3:0] maskIn;
  logic       MASKld;
  logic       intEnable;
  logic       intDisable;
  logic       clrPend;
  logic       intPending;
  logic [1:0] intId;
  logic [7:0] intVector;
  logic       inService;
  logic [3:0] maskOut;

  int checks = 0;
  int errors = 0;

  intc_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .maskIn     (maskIn),
    .MASKld     (MASKld),
    .intEnable  (intEnable),
    .intDisable (intDisable),
    .clrPend    (clrPend),
    .intPending (intPending),
    .intId      (intId),
    .intVector  (intVector),
    .inService  (inService),
    .maskOut    (maskOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; irq = 4'b0; maskIn = 4'b0; MASKld = 1'b0;
    intEnable = 1'b0; intDisable = 1'b0; clrPend = 1'b0;

    // Reset state
    tick(2);
    chk("rst_pending", 32'(intPending), 32'd0);
    chk("rst_insvc",   32'(inService),  32'd0);
    chk("rst_id",      32'(intId),      32'd0);
    chk("rst_vec",     32'(intVector),  32'hF0);
    chk("rst_mask",    32'(maskOut),    32'd0);
    rst_n = 1'b1;
    tick(1);

    // 1: enable, irq[2] rises -> presented after the 4th edge
    intEnable = 1'b1; tick(1); intEnable = 1'b0;
    irq = 4'b0100;
    tick(3);
    chk("t1_not_yet_E3", 32'(intPending), 32'd0);
    tick(1);
    chk("t1_pending_E4", 32'(intPending), 32'd1);
    chk("t1_id",         32'(intId),      32'd2);
    chk("t1_vec",        32'(intVector),  32'hF2);
    clrPend = 1'b1; tick(1); clrPend = 1'b0;
    irq = 4'b0000;
    chk("t1_insvc",      32'(inService),  32'd1);
    chk("t1_pend_low",   32'(intPending), 32'd0);
    chk("t1_id_held",    32'(intId),      32'd2);
    intEnable = 1'b1; tick(1); intEnable = 1'b0;
    chk("t1_ret_insvc",  32'(inService),  32'd0);
    tick(3);
    chk("t1_cleared",    32'(intPending), 32'd0);

    // 2: irq[3] and irq[1] together -> 1 first, then 3
    irq = 4'b1010;
    tick(4);
    chk("t2_pending",    32'(intPending), 32'd1);
    chk("t2_id1",        32'(intId),      32'd1);
    chk("t2_vec1",       32'(intVector),  32'hF1);
    irq = 4'b0000;
    clrPend = 1'b1; tick(1); clrPend = 1'b0;
    chk("t2_insvc",      32'(inService),  32'd1);
    intEnable = 1'b1; tick(1); intEnable = 1'b0;
    tick(1);
    chk("t2_pending3",   32'(intPending), 32'd1);
    chk("t2_id3",        32'(intId),      32'd3);
    chk("t2_vec3",       32'(intVector),  32'hF3);
    clrPend = 1'b1; tick(1); clrPend = 1'b0;
    intEnable = 1'b1; tick(1); intEnable = 1'b0;
    tick(3);

    // 3: mask line 1 while it is requested
    irq = 4'b0010;
    tick(4);
    chk("t3_req_id1",    32'(intId),      32'd1);
    chk("t3_req",        32'(intPending), 32'd1);
    maskIn = 4'b0010; MASKld = 1'b1; tick(1); MASKld = 1'b0;
    chk("t3_maskout",    32'(maskOut),    32'h2);
    chk("t3_still_req",  32'(intPending), 32'd1);
    tick(1);
    chk("t3_aborted",    32'(intPending), 32'd0);
    tick(2);
    chk("t3_stays_idle", 32'(intPending), 32'd0);
    maskIn = 4'b0000; MASKld = 1'b1; tick(1); MASKld = 1'b0;
    tick(1);
    chk("t3_re_req",     32'(intPending), 32'd1);
    chk("t3_re_id",      32'(intId),      32'd1);
    irq = 4'b0000;
    clrPend = 1'b1; tick(1); clrPend = 1'b0;
    intEnable = 1'b1; tick(1); intEnable = 1'b0;
    tick(3);

    // 4: enable and disable together -> disabled
    intEnable = 1'b1; intDisable = 1'b1; tick(1);
    intEnable = 1'b0; intDisable = 1'b0;
    irq = 4'b0001;
    tick(6);
    chk("t4_disabled",   32'(intPending), 32'd0);
    intEnable = 1'b1; tick(1); intEnable = 1'b0;
    tick(1);
    chk("t4_req",        32'(intPending), 32'd1);
    chk("t4_id0",        32'(intId),      32'd0);
    chk("t4_vec0",       32'(intVector),  32'hF0);

    // 5: new irq[0] edge and stray clrPend while in SERVICE
    clrPend = 1'b1; tick(1); clrPend = 1'b0;
    irq = 4'b0000;
    tick(3);
    irq = 4'b0001;
    tick(2);
    clrPend = 1'b1; tick(1); clrPend = 1'b0;
    tick(3);
    chk("t5_insvc",      32'(inService),  32'd1);
    chk("t5_no_req",     32'(intPending), 32'd0);
    chk("t5_id_held",    32'(intId),      32'd0);
    intEnable = 1'b1; tick(1); intEnable = 1'b0;
    chk("t5_ret",        32'(inService),  32'd0);
    tick(1);
    chk("t5_req0",       32'(intPending), 32'd1);
    clrPend = 1'b1; tick(1); clrPend = 1'b0;
    chk("t5_insvc2",     32'(inService),  32'd1);

    // 6: reset in SERVICE with irq[0] held high
    maskIn = 4'b1000; MASKld = 1'b1; tick(1); MASKld = 1'b0;
    chk("t6_mask",       32'(maskOut),    32'h8);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_insvc",  32'(inService),  32'd0);
    chk("t6_rst_pend",   32'(intPending), 32'd0);
    chk("t6_rst_id",     32'(intId),      32'd0);
    chk("t6_rst_vec",    32'(intVector),  32'hF0);
    chk("t6_rst_mask",   32'(maskOut),    32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("t6_gen_off",    32'(intPending), 32'd0);
    intEnable = 1'b1; tick(1); intEnable = 1'b0;
    tick(1);
    chk("t6_held_req",   32'(intPending), 32'd1);
    chk("t6_held_id",    32'(intId),      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
